// File: rtl/mac_pkg.sv
// Shared widths, defaults and state encoding for the mac operand path.
// Lane j of a packed lane bus occupies bits [lane_lo(j) +: OP_W].
package mac_pkg;

  localparam int OP_W       = 8;
  localparam int ACC_W      = 16;
  localparam int N_ELEM_DEF = 25;
  localparam int IDX_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  function automatic int lane_lo(input int j);
    return j * OP_W;
  endfunction

endpackage

// File: rtl/mac_operand_buf.sv
// Two N_ELEM x 8 operand register files, one sync write port and
// PARALLEL combinational read ports; out-of-range reads return 0.
module mac_operand_buf
  import mac_pkg::*;
#(
  parameter int N_ELEM   = N_ELEM_DEF,
  parameter int PARALLEL = 1
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      we,
  input  logic                      sel,
  input  logic [IDX_W-1:0]          waddr,
  input  logic [OP_W-1:0]           wdata,
  input  logic [PARALLEL*IDX_W-1:0] raddr,
  output logic [PARALLEL*OP_W-1:0]  rdata_a,
  output logic [PARALLEL*OP_W-1:0]  rdata_b
);

  logic [OP_W-1:0] a_q [N_ELEM];
  logic [OP_W-1:0] a_d [N_ELEM];
  logic [OP_W-1:0] b_q [N_ELEM];
  logic [OP_W-1:0] b_d [N_ELEM];

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int i = 0; i < N_ELEM; i++) begin
      if (we && waddr == IDX_W'(i)) begin
        if (sel) b_d[i] = wdata;
        else     a_d[i] = wdata;
      end
    end
  end

  // Reads see the post-write view so a same-cycle write+launch
  // streams the freshly written value.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int p = 0; p < PARALLEL; p++) begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (raddr[p*IDX_W +: IDX_W] == IDX_W'(i)) begin
          rdata_a[lane_lo(p) +: OP_W] = a_d[i];
          rdata_b[lane_lo(p) +: OP_W] = b_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams buffered A/B operands into a mac under start/done and
// returns the captured accumulator with a one-cycle valid pulse.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int PARALLEL    = 1,
  parameter int N_ELEM      = N_ELEM_DEF,
  parameter int TIMEOUT_CYC = 500
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [4:0]               wr_addr,
  input  logic [OP_W-1:0]          wr_data,
  input  logic                     go,
  output logic                     busy,
  output logic [PARALLEL*OP_W-1:0] mac_din_a,
  output logic [PARALLEL*OP_W-1:0] mac_din_b,
  output logic                     mac_start,
  input  logic                     mac_done,
  input  logic [ACC_W-1:0]         mac_dout,
  output logic [ACC_W-1:0]         result,
  output logic                     result_valid,
  output logic                     timeout_err
);

  localparam int LW = PARALLEL * OP_W;
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             rv_q, rv_d;
  logic             terr_q, terr_d;
  logic [LW-1:0]    din_a_q, din_a_d;
  logic [LW-1:0]    din_b_q, din_b_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             go_q, done_q;

  logic [PARALLEL*IDX_W-1:0] raddr;
  logic [LW-1:0]    rd_a, rd_b;
  logic [IDX_W-1:0] rbase;
  logic             launch, done_rise, wr_ok;

  assign wr_ok     = wr_en & ~busy_q;
  assign launch    = (state_q == ST_IDLE) & go & ~go_q;
  assign done_rise = mac_done & ~done_q;
  assign rbase     = (state_q == ST_IDLE) ? '0 : idx_q;

  always_comb begin
    raddr = '0;
    for (int j = 0; j < PARALLEL; j++)
      raddr[j*IDX_W +: IDX_W] = rbase + IDX_W'(j);
  end

  mac_operand_buf #(
    .N_ELEM   (N_ELEM),
    .PARALLEL (PARALLEL)
  ) u_buf (
    .clk     (clk),
    .rst_b   (rst_b),
    .we      (wr_ok),
    .sel     (wr_sel),
    .waddr   ({1'b0, wr_addr}),
    .wdata   (wr_data),
    .raddr   (raddr),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    start_d = start_q;
    rv_d    = 1'b0;
    terr_d  = terr_q;
    din_a_d = din_a_q;
    din_b_d = din_b_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_PRIME;
          busy_d  = 1'b1;
          terr_d  = 1'b0;
          din_a_d = rd_a;
          din_b_d = rd_b;
          idx_d   = IDX_W'(PARALLEL);
        end
      end
      ST_PRIME: begin
        state_d = ST_STREAM;
        start_d = 1'b1;
        cnt_d   = '0;
      end
      ST_STREAM: begin
        // A done edge on the timeout cycle still counts as success.
        if (done_rise) begin
          res_d   = mac_dout;
          rv_d    = 1'b1;
          start_d = 1'b0;
          busy_d  = 1'b0;
          din_a_d = '0;
          din_b_d = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          terr_d  = 1'b1;
          start_d = 1'b0;
          busy_d  = 1'b0;
          din_a_d = '0;
          din_b_d = '0;
          state_d = ST_IDLE;
        end else begin
          din_a_d = rd_a;
          din_b_d = rd_b;
          cnt_d   = cnt_q + 1'b1;
          if (idx_q < IDX_W'(N_ELEM))
            idx_d = idx_q + IDX_W'(PARALLEL);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      terr_q  <= 1'b0;
      din_a_q <= '0;
      din_b_q <= '0;
      res_q   <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      rv_q    <= rv_d;
      terr_q  <= terr_d;
      din_a_q <= din_a_d;
      din_b_q <= din_b_d;
      res_q   <= res_d;
      go_q    <= go;
      done_q  <= mac_done;
    end
  end

  assign busy         = busy_q;
  assign mac_start    = start_q;
  assign result_valid = rv_q;
  assign timeout_err  = terr_q;
  assign mac_din_a    = din_a_q;
  assign mac_din_b    = din_b_q;
  assign result       = res_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench: three feeders (PARALLEL 1/5/4) share stimulus; each has a mac model.
// Expected lanes and results come from shadow buffers and a dot product.
module tb_mac_operand_feeder;
  import mac_pkg::*;

  localparam int N    = 25;
  localparam int NI   = 3;
  localparam int MAXW = 40;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       go = 1'b0;
  bit         no_done = 1'b0;

  logic            busy   [NI];
  logic            start  [NI];
  logic            rv     [NI];
  logic            terr   [NI];
  logic [MAXW-1:0] din_a  [NI];
  logic [MAXW-1:0] din_b  [NI];
  logic [15:0]     result [NI];

  logic [7:0] sa [N];
  logic [7:0] sb [N];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int rv_cnt  [NI];
  int to_cnt  [NI];
  int t_start [NI];
  int k       [NI];
  bit terr_p  [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int p_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 5 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int P = (g == 0) ? 1 : ((g == 1) ? 5 : 4);
    logic [P*8-1:0] da, db;
    logic           md;
    logic [15:0]    mdo;
    int acc, beats, wait_n;

    mac_operand_feeder #(
      .PARALLEL    (P),
      .N_ELEM      (N),
      .TIMEOUT_CYC (500)
    ) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .wr_en        (wr_en),
      .wr_sel       (wr_sel),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .go           (go),
      .busy         (busy[g]),
      .mac_din_a    (da),
      .mac_din_b    (db),
      .mac_start    (start[g]),
      .mac_done     (md),
      .mac_dout     (mdo),
      .result       (result[g]),
      .result_valid (rv[g]),
      .timeout_err  (terr[g])
    );

    assign din_a[g] = MAXW'(da);
    assign din_b[g] = MAXW'(db);

    // mac model: accumulate while start, done two cycles after last real beat
    always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        acc = 0; beats = 0; wait_n = -1;
        md <= 1'b0; mdo <= '0;
      end else if (!start[g]) begin
        acc = 0; beats = 0; wait_n = -1;
        md <= 1'b0;
      end else begin
        for (int j = 0; j < P; j++)
          acc += int'(da[j*8 +: 8]) * int'(db[j*8 +: 8]);
        beats++;
        if (beats == (N + P - 1) / P) wait_n = 2;
        else if (wait_n > 0) wait_n--;
        if (wait_n == 0 && !no_done) md <= 1'b1;
        mdo <= 16'(acc);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dot();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(sa[i]) * int'(sb[i]);
    return 16'(s);
  endfunction

  always @(negedge clk) begin
    int e, p;
    logic [7:0] ea, eb;
    for (int g = 0; g < NI; g++) begin
      p = p_of(g);
      if (!rst_b) begin
        k[g] = 0;
        terr_p[g] = 1'b0;
      end else begin
        if (start[g]) begin
          if (k[g] == 0) t_start[g] = cyc;
          if (k[g] * p < N + p) begin
            for (int j = 0; j < p; j++) begin
              e = k[g] * p + j;
              ea = '0;
              eb = '0;
              if (e < N) begin
                ea = sa[e];
                eb = sb[e];
              end
              chk($sformatf("lane_a i%0d beat%0d l%0d", g, k[g], j),
                  din_a[g][j*8 +: 8], ea);
              chk($sformatf("lane_b i%0d beat%0d l%0d", g, k[g], j),
                  din_b[g][j*8 +: 8], eb);
            end
          end
          k[g]++;
        end else begin
          k[g] = 0;
        end
        if (rv[g]) begin
          rv_cnt[g]++;
          chk($sformatf("result i%0d", g), result[g], dot());
        end
        if (terr[g] && !terr_p[g]) begin
          to_cnt[g]++;
          chk($sformatf("tmo_cycles i%0d", g), cyc - t_start[g], 500);
          chk($sformatf("tmo_start i%0d", g), start[g], 0);
          chk($sformatf("tmo_busy i%0d", g), busy[g], 0);
        end
        terr_p[g] = terr[g];
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit s, input int a, input logic [7:0] d);
    wr_sel  = s;
    wr_addr = 5'(a);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    if (a < N) begin
      if (s) sb[a] = d;
      else   sa[a] = d;
    end
  endtask

  task automatic load(input int mode);
    logic [7:0] a, b;
    for (int i = 0; i < N; i++) begin
      case (mode)
        1:       begin a = 8'd1; b = 8'(i + 1); end
        2:       begin a = 8'd2; b = 8'd3;      end
        3:       begin a = 8'd1; b = 8'd1;      end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      wr(1'b0, i, a);
      wr(1'b1, i, b);
    end
    wr(1'($urandom), 25 + int'($urandom_range(0, 6)), 8'($urandom));
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s busy i%0d", tag, g), busy[g], 0);
      chk($sformatf("%s start i%0d", tag, g), start[g], 0);
      chk($sformatf("%s rv i%0d", tag, g), rv[g], 0);
      chk($sformatf("%s terr i%0d", tag, g), terr[g], 0);
      chk($sformatf("%s result i%0d", tag, g), result[g], 0);
      chk($sformatf("%s din_a i%0d", tag, g), din_a[g], 0);
      chk($sformatf("%s din_b i%0d", tag, g), din_b[g], 0);
    end
  endtask

  function automatic bit any_busy();
    bit b;
    b = 1'b0;
    for (int g = 0; g < NI; g++) b |= busy[g];
    return b;
  endfunction

  task automatic run(input bit exp_done, input bit held, input bit meddle);
    int c0 [NI];
    int t0 [NI];
    int t;
    for (int g = 0; g < NI; g++) begin
      c0[g] = rv_cnt[g];
      t0[g] = to_cnt[g];
    end
    go = 1'b1;
    tick();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("accept_busy i%0d", g), busy[g], 1);
      chk($sformatf("prime_start i%0d", g), start[g], 0);
      chk($sformatf("accept_terr i%0d", g), terr[g], 0);
    end
    if (!held) go = 1'b0;
    tick();
    for (int g = 0; g < NI; g++)
      chk($sformatf("stream_start i%0d", g), start[g], 1);
    if (meddle) begin
      repeat (3) begin
        wr_sel  = 1'($urandom);
        wr_addr = 5'($urandom_range(0, 24));
        wr_data = 8'($urandom);
        wr_en   = 1'b1;
        go      = ~go;
        tick();
      end
      wr_en = 1'b0;
      go    = held;
    end
    t = 0;
    while (any_busy() && t < 1000) begin
      tick();
      t++;
    end
    chk("idle_bound", t < 1000, 1);
    tick(3);
    go = 1'b0;
    tick(2);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rv_count i%0d", g), rv_cnt[g] - c0[g], exp_done ? 1 : 0);
      chk($sformatf("to_count i%0d", g), to_cnt[g] - t0[g], exp_done ? 0 : 1);
      chk($sformatf("terr_end i%0d", g), terr[g], exp_done ? 0 : 1);
      if (exp_done)
        chk($sformatf("result_hold i%0d", g), result[g], dot());
    end
  endtask

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      sa[i] = '0;
      sb[i] = '0;
    end
    for (int g = 0; g < NI; g++) begin
      rv_cnt[g] = 0; to_cnt[g] = 0; t_start[g] = 0;
    end
    rst_b = 1'b0;
    tick(2);
    chk_zero("reset");
    rst_b = 1'b1;
    tick();

    load(1);
    run(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < NI; g++) chk("s1_const", result[g], 16'h0145);

    load(2);
    run(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < NI; g++) chk("s2_const", result[g], 16'h0096);

    load(3);
    run(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < NI; g++) chk("s3_const", result[g], 16'h0019);

    no_done = 1'b1;
    run(1'b0, 1'b0, 1'b0);
    no_done = 1'b0;
    for (int g = 0; g < NI; g++) chk("tmo_result_kept", result[g], 16'h0019);

    load(0);
    run(1'b1, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 1'b1);
    run(1'b1, 1'b0, 1'b0);

    load(1);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(11);
    c = rv_cnt[0];
    #2 rst_b = 1'b0;
    #1 chk_zero("midrst");
    for (int i = 0; i < N; i++) begin
      sa[i] = '0;
      sb[i] = '0;
    end
    tick(2);
    rst_b = 1'b1;
    tick(40);
    chk("no_rv_after_rst", rv_cnt[0], c);
    load(1);
    run(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < NI; g++) chk("s5_const", result[g], 16'h0145);

    repeat (4) begin
      load(0);
      run(1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
